// File: rtl/reset_sequencer.sv
// reset_sequencer: owns the SoC reset domains and the watchdog start/kick.
// Sequence: ASSERT -> HOLD -> (RELEASE -> WAIT_READY -> GAP)* -> RUN.
// Domains are released one at a time, lowest index first. The FSM waits for
// each domain's ready acknowledge, with a timeout that leads to FAIL.
// Every output is a flop whose next value comes from the next state, so an
// output changes in the same cycle as the state it describes.
// Optional feature: define RESET_SEQ_RETRY_EN to turn FAIL into a bounded
// auto-retry. The FSM retries up to 3 consecutive times with cause TIMEOUT.
// Without the macro, FAIL is terminal until a software request edge or rstn.
module reset_sequencer #(
  parameter int unsigned NUM_DOMAINS   = 4,
  parameter int unsigned HOLD_CYCLES   = 100000,
  parameter int unsigned STAGE_GAP     = 1024,
  parameter int unsigned READY_TIMEOUT = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wdt_reset_i,
  input  logic                   sw_reset_req_i,
  input  logic                   heartbeat_i,
  input  logic [NUM_DOMAINS-1:0] domain_ready_i,
  output logic [NUM_DOMAINS-1:0] domain_rstn_o,
  output logic                   wdt_start_o,
  output logic                   wdt_kick_o,
  output logic                   busy_o,
  output logic                   fail_o,
  output logic [1:0]             reset_cause_o,
  output logic [7:0]             reset_count_o
);

  localparam int unsigned   KW        = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [KW-1:0] LAST_K    = KW'(NUM_DOMAINS - 1);
  localparam logic [31:0]   HOLD_LAST = 32'(HOLD_CYCLES - 1);
  // Only used when STAGE_GAP > 0; for 0 the GAP state is never entered.
  localparam logic [31:0]   GAP_LAST  = 32'(STAGE_GAP - 1);
  localparam logic [31:0]   TO_LAST   = 32'(READY_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_WDT     = 2'b01;
  localparam logic [1:0] CAUSE_SW      = 2'b10;
`ifdef RESET_SEQ_RETRY_EN
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;
`endif

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_WAIT_READY,
    ST_GAP,
    ST_RUN,
    ST_FAIL
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [KW-1:0]          k_q, k_d;
  logic [NUM_DOMAINS-1:0] domain_rstn_q, domain_rstn_d;
  logic                   wdt_start_q, wdt_start_d;
  logic                   wdt_kick_q, wdt_kick_d;
  logic                   busy_q, busy_d;
  logic                   fail_q, fail_d;
  logic [1:0]             cause_q, cause_d;
  logic [7:0]             count_q, count_d;
  logic                   wdt_prev_q, wdt_prev_d;
  logic                   sw_prev_q, sw_prev_d;
  logic                   wdt_rise, sw_rise;
`ifdef RESET_SEQ_RETRY_EN
  logic [1:0]             retry_q, retry_d;
`endif

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    k_d           = k_q;
    domain_rstn_d = domain_rstn_q;
    cause_d       = cause_q;
    count_d       = count_q;
`ifdef RESET_SEQ_RETRY_EN
    retry_d       = retry_q;
`endif
    // Edge detectors track the inputs in every state, so a level held
    // across a whole sequence does not fire again when RUN is reached.
    wdt_prev_d = wdt_reset_i;
    sw_prev_d  = sw_reset_req_i;
    wdt_rise   = wdt_reset_i & ~wdt_prev_q;
    sw_rise    = sw_reset_req_i & ~sw_prev_q;

    case (state_q)
      ST_ASSERT: begin
        cnt_d         = '0;
        k_d           = '0;
        domain_rstn_d = '0;
        state_d       = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_RELEASE: begin
        // Once released, a domain stays released until the next ASSERT.
        domain_rstn_d[k_q] = 1'b1;
        cnt_d              = '0;
        state_d            = ST_WAIT_READY;
      end
      ST_WAIT_READY: begin
        if (domain_ready_i[k_q]) begin
          cnt_d = '0;
          if (k_q == LAST_K) begin
            state_d = ST_RUN;
          end else if (STAGE_GAP == 0) begin
            k_d     = k_q + KW'(1);
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_GAP;
          end
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          state_d = ST_FAIL;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          k_d     = k_q + KW'(1);
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_RUN: begin
        // Watchdog wins when both requests rise in the same cycle.
        if (wdt_rise) begin
          cause_d = CAUSE_WDT;
          state_d = ST_ASSERT;
        end else if (sw_rise) begin
          cause_d = CAUSE_SW;
          state_d = ST_ASSERT;
        end
      end
      ST_FAIL: begin
        // A software request edge is the only request honoured outside RUN.
        if (sw_rise) begin
          cause_d = CAUSE_SW;
          state_d = ST_ASSERT;
        end
`ifdef RESET_SEQ_RETRY_EN
        else if (retry_q != 2'd3) begin
          cause_d = CAUSE_TIMEOUT;
          retry_d = retry_q + 2'd1;
          state_d = ST_ASSERT;
        end
`endif
      end
      default: state_d = ST_ASSERT;
    endcase

`ifdef RESET_SEQ_RETRY_EN
    // A sequence that reaches RUN gets a fresh retry budget.
    if (state_d == ST_RUN) retry_d = 2'd0;
`endif

    // Entering ASSERT (never from rstn, which bypasses this logic) pulls all
    // domains into reset and bumps the saturating reset counter.
    if (state_d == ST_ASSERT) begin
      domain_rstn_d = '0;
      if (state_q != ST_ASSERT && count_q != 8'hFF) count_d = count_q + 8'd1;
    end

    wdt_start_d = (state_d == ST_RUN);
    // The kick only follows the heartbeat while staying in RUN, so the
    // watchdog count is held clear everywhere else.
    wdt_kick_d  = heartbeat_i && (state_q == ST_RUN) && (state_d == ST_RUN);
    busy_d      = (state_d != ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  // State, counters, edge detectors and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_ASSERT;
      cnt_q         <= '0;
      k_q           <= '0;
      domain_rstn_q <= '0;
      wdt_start_q   <= 1'b0;
      wdt_kick_q    <= 1'b0;
      busy_q        <= 1'b1;
      fail_q        <= 1'b0;
      cause_q       <= 2'b00;
      count_q       <= 8'd0;
      wdt_prev_q    <= 1'b0;
      sw_prev_q     <= 1'b0;
`ifdef RESET_SEQ_RETRY_EN
      retry_q       <= 2'd0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      k_q           <= k_d;
      domain_rstn_q <= domain_rstn_d;
      wdt_start_q   <= wdt_start_d;
      wdt_kick_q    <= wdt_kick_d;
      busy_q        <= busy_d;
      fail_q        <= fail_d;
      cause_q       <= cause_d;
      count_q       <= count_d;
      wdt_prev_q    <= wdt_prev_d;
      sw_prev_q     <= sw_prev_d;
`ifdef RESET_SEQ_RETRY_EN
      retry_q       <= retry_d;
`endif
    end
  end

  assign domain_rstn_o = domain_rstn_q;
  assign wdt_start_o   = wdt_start_q;
  assign wdt_kick_o    = wdt_kick_q;
  assign busy_o        = busy_q;
  assign fail_o        = fail_q;
  assign reset_cause_o = cause_q;
  assign reset_count_o = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer (NUM_DOMAINS=2, HOLD=8, GAP=4, TIMEOUT=16).
// The output vector is packed as
// {domain_rstn[1:0], start, kick, busy, fail, cause[1:0], count[7:0]}.
// Expectations carry a cycle stamp: the driver pushes them to a queue, and a
// negedge checker pops and compares each one at its stamped cycle.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wdt = 1'b0, sw = 1'b0, hb = 1'b0;
  logic [1:0] rdy = 2'b11;
  logic [1:0] drstn;
  logic       start, kick, busy, fail;
  logic [1:0] cause;
  logic [7:0] count;

  reset_sequencer #(
    .NUM_DOMAINS(2), .HOLD_CYCLES(8), .STAGE_GAP(4), .READY_TIMEOUT(16)
  ) dut (
    .clk(clk), .rstn(rstn), .wdt_reset_i(wdt), .sw_reset_req_i(sw),
    .heartbeat_i(hb), .domain_ready_i(rdy), .domain_rstn_o(drstn),
    .wdt_start_o(start), .wdt_kick_o(kick), .busy_o(busy), .fail_o(fail),
    .reset_cause_o(cause), .reset_count_o(count)
  );

  always #5 clk = ~clk;

  // cyc equals the spec cycle number: 0 is the first cycle with rstn high.
  int cyc = 0;
  always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

  localparam logic [15:0] ALL     = 16'hFFFF;
  localparam logic [15:0] NO_RSTN = 16'h3FFF;
  localparam logic [15:0] NO_SB   = 16'hD7FF;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] exp;
    logic [15:0] mask;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [1:0]  rdy;
    logic        hb;
    logic [15:0] exp;
    logic [15:0] mask;
    string       name;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  wire [15:0] act = {drstn, start, kick, busy, fail, cause, count};

  function automatic logic [15:0] ov(input logic [1:0] r, input logic s, input logic k,
                                     input logic b, input logic f, input logic [1:0] c,
                                     input logic [7:0] n);
    return {r, s, k, b, f, c, n};
  endfunction

  task automatic push(input int c, input string name, input logic [15:0] e,
                      input logic [15:0] m);
    exp_t x;
    x.cyc = c; x.name = name; x.exp = e; x.mask = m;
    sbq.push_back(x);
  endtask

  // Advances to posedge+1 of cycle n.
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      $display("FAIL drain: %0d expectations still pending at cycle %0d", sbq.size(), cyc);
      $fatal(1, "scoreboard stuck");
    end
  endtask

  // Scoreboard checker: compares every expectation stamped with this cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      checks++;
      if (sbq[0].cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)",
                 sbq[0].name, sbq[0].cyc, cyc);
      end else if ((act & sbq[0].mask) !== (sbq[0].exp & sbq[0].mask)) begin
        errors++;
        $display("FAIL %s @cycle %0d: got %h, required %h (mask %h)",
                 sbq[0].name, cyc, act & sbq[0].mask, sbq[0].exp & sbq[0].mask, sbq[0].mask);
      end
      void'(sbq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] cnt_e;
    int         base;

    // Power-on sequence and heartbeat in RUN, table driven.
    tbl.push_back('{0,  2'b11, 1'b0, ov(2'b00,0,0,1,0,2'b00,8'd0), ALL,     "por_reset_state"});
    tbl.push_back('{5,  2'b11, 1'b0, ov(2'b00,0,0,1,0,2'b00,8'd0), ALL,     "por_hold"});
    tbl.push_back('{9,  2'b11, 1'b0, ov(2'b00,0,0,1,0,2'b00,8'd0), ALL,     "por_release_cycle"});
    tbl.push_back('{10, 2'b11, 1'b0, ov(2'b01,0,0,1,0,2'b00,8'd0), ALL,     "por_dom0_up"});
    tbl.push_back('{15, 2'b11, 1'b0, ov(2'b01,0,0,1,0,2'b00,8'd0), ALL,     "por_gap_end"});
    tbl.push_back('{16, 2'b11, 1'b0, ov(2'b11,0,0,1,0,2'b00,8'd0), NO_RSTN, "por_not_running"});
    tbl.push_back('{17, 2'b11, 1'b0, ov(2'b11,1,0,0,0,2'b00,8'd0), NO_SB,   "por_dom1_up"});
    tbl.push_back('{18, 2'b11, 1'b0, ov(2'b11,1,0,0,0,2'b00,8'd0), ALL,     "por_run"});
    tbl.push_back('{20, 2'b11, 1'b1, ov(2'b11,1,0,0,0,2'b00,8'd0), ALL,     "hb_driven"});
    tbl.push_back('{21, 2'b11, 1'b0, ov(2'b11,1,1,0,0,2'b00,8'd0), ALL,     "kick_pulse"});
    tbl.push_back('{22, 2'b11, 1'b0, ov(2'b11,1,0,0,0,2'b00,8'd0), ALL,     "kick_end"});

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      wait_cyc(tbl[i].cyc);
      rdy = tbl[i].rdy;
      hb  = tbl[i].hb;
      push(tbl[i].cyc, tbl[i].name, tbl[i].exp, tbl[i].mask);
    end
    drain();

    // Long watchdog pulse: one sequence only, cause WDT.
    wait_cyc(30);
    wdt = 1'b1;
    push(30,  "wdt_edge_cycle", ov(2'b11,1,0,0,0,2'b00,8'd0), ALL);
    push(31,  "wdt_assert",     ov(2'b00,0,0,1,0,2'b01,8'd1), ALL);
    push(41,  "wdt_dom0_up",    ov(2'b01,0,0,1,0,2'b01,8'd1), ALL);
    push(60,  "wdt_run",        ov(2'b11,1,0,0,0,2'b01,8'd1), ALL);
    wait_cyc(130);
    wdt = 1'b0;
    push(135, "wdt_no_retrig",  ov(2'b11,1,0,0,0,2'b01,8'd1), ALL);
    drain();

    // Both requests rise together: WDT wins, count +1.
    wait_cyc(150);
    wdt = 1'b1;
    sw  = 1'b1;
    push(151, "both_assert", ov(2'b00,0,0,1,0,2'b01,8'd2), ALL);
    push(169, "both_run",    ov(2'b11,1,0,0,0,2'b01,8'd2), ALL);
    wait_cyc(170);
    wdt = 1'b0;
    sw  = 1'b0;
    push(175, "both_run_held", ov(2'b11,1,0,0,0,2'b01,8'd2), ALL);
    drain();

    // Domain 1 never acknowledges: timeout into FAIL.
    wait_cyc(200);
    rdy = 2'b01;
    sw  = 1'b1;
    push(201, "stuck_assert", ov(2'b00,0,0,1,0,2'b10,8'd3), ALL);
    wait_cyc(205);
    hb = 1'b1;
    push(206, "hb_outside_run", ov(2'b00,0,0,1,0,2'b10,8'd3), ALL);
    wait_cyc(206);
    hb = 1'b0;
    wait_cyc(210);
    sw = 1'b0;
    push(211, "stuck_dom0_up",  ov(2'b01,0,0,1,0,2'b10,8'd3), ALL);
    push(232, "stuck_last_wait", ov(2'b11,0,0,1,0,2'b10,8'd3), ALL);
    push(233, "stuck_fail",     ov(2'b11,0,0,1,1,2'b10,8'd3), ALL);
`ifdef RESET_SEQ_RETRY_EN
    push(234, "retry1",        ov(2'b00,0,0,1,0,2'b11,8'd4), ALL);
    push(267, "retry2",        ov(2'b00,0,0,1,0,2'b11,8'd5), ALL);
    push(300, "retry3",        ov(2'b00,0,0,1,0,2'b11,8'd6), ALL);
    push(331, "retry3_wait",   ov(2'b11,0,0,1,0,2'b11,8'd6), ALL);
    push(332, "retry_fail",    ov(2'b11,0,0,1,1,2'b11,8'd6), ALL);
    push(360, "retry_fail_stays", ov(2'b11,0,0,1,1,2'b11,8'd6), ALL);
    wait_cyc(370);
    sw  = 1'b1;
    rdy = 2'b11;
    push(371, "fail_sw_exit",  ov(2'b00,0,0,1,0,2'b10,8'd7), ALL);
    push(395, "fail_sw_run",   ov(2'b11,1,0,0,0,2'b10,8'd7), ALL);
    wait_cyc(395);
    sw    = 1'b0;
    cnt_e = 8'd8;
    base  = 420;
`else
    push(250, "fail_stays",    ov(2'b11,0,0,1,1,2'b10,8'd3), ALL);
    wait_cyc(260);
    sw  = 1'b1;
    rdy = 2'b11;
    push(261, "fail_sw_exit",  ov(2'b00,0,0,1,0,2'b10,8'd4), ALL);
    push(285, "fail_sw_run",   ov(2'b11,1,0,0,0,2'b10,8'd4), ALL);
    wait_cyc(285);
    sw    = 1'b0;
    cnt_e = 8'd5;
    base  = 300;
`endif
    drain();

    // rstn dropped during GAP: reset values next cycle, then a POR sequence.
    wait_cyc(base);
    sw = 1'b1;
    push(base + 1,  "gap_seq_assert", ov(2'b00,0,0,1,0,2'b10,cnt_e), ALL);
    push(base + 12, "gap_seq_gap",    ov(2'b01,0,0,1,0,2'b10,cnt_e), ALL);
    drain();
    wait_cyc(base + 13);
    rstn = 1'b0;
    sw   = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    push(0,  "rst_in_gap",    ov(2'b00,0,0,1,0,2'b00,8'd0), ALL);
    push(10, "por2_dom0_up",  ov(2'b01,0,0,1,0,2'b00,8'd0), ALL);
    push(18, "por2_run",      ov(2'b11,1,0,0,0,2'b00,8'd0), ALL);
    wait_cyc(20);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
